// File: rtl/core_stim_seq_if.sv
// Store-trace read channel: producer presents the head entry, consumer pops with tr_ready.
interface core_stim_seq_if #(
  parameter int XLEN = 32
);
  logic            tr_valid;
  logic            tr_ready;
  logic [XLEN-1:0] tr_pc;
  logic [XLEN-1:0] tr_addr;
  logic [XLEN-1:0] tr_data;

  modport master (output tr_valid, tr_pc, tr_addr, tr_data, input tr_ready);
  modport slave  (input tr_valid, tr_pc, tr_addr, tr_data, output tr_ready);
endinterface

// File: rtl/core_stim_seq.sv
// Replays a stored program into a core (run-once/loop/single-step) after a core reset pulse,
// capturing the core's stores into a FWFT trace FIFO; a full FIFO drops pushes and flags overflow.
module core_stim_seq #(
  parameter int XLEN        = 32,
  parameter int PROG_DEPTH  = 16,
  parameter int TRACE_DEPTH = 8,
  parameter int RST_HOLD    = 2,
  localparam int PAW = $clog2(PROG_DEPTH),
  localparam int TAW = $clog2(TRACE_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [1:0]      mode,
  input  logic            step,
  input  logic            prog_we,
  input  logic [PAW-1:0]  prog_addr,
  input  logic [XLEN-1:0] prog_wdata,
  input  logic [PAW:0]    prog_len,
  output logic            core_reset,
  output logic [XLEN-1:0] Instruction,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] ALURes,
  input  logic [XLEN-1:0] WriteData,
  input  logic            MemWrite,
  core_stim_seq_if.master tr,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [TAW:0]    tr_count
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {IDLE, CRST, RUN, STEP, DONE} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } tr_ent_t;

  state_t          state;
  logic [PAW-1:0]  idx;
  logic [PAW-1:0]  last;
  logic            loop_q;
  logic            step_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] prog [PROG_DEPTH];

  logic idle_like;
  logic start_ok;
  logic at_last;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign start_ok  = idle_like && start && (prog_len != '0) &&
                     (prog_len <= (PAW+1)'(PROG_DEPTH));
  assign at_last   = (idx == last);

  // Program storage survives block reset so a replay after reset needs no reload.
  always_ff @(posedge clk) begin
    if (prog_we && idle_like)
      prog[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      last        <= '0;
      loop_q      <= 1'b0;
      step_q      <= 1'b0;
      cnt         <= '0;
      core_reset  <= 1'b1;
      Instruction <= NOP;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      idx         <= '0;
      core_reset  <= 1'b1;
      Instruction <= NOP;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state       <= CRST;
            cnt         <= '0;
            idx         <= '0;
            last        <= PAW'(prog_len - 1'b1);
            loop_q      <= (mode == 2'b01);
            step_q      <= (mode == 2'b10);
            core_reset  <= 1'b1;
            Instruction <= NOP;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        CRST: begin
          if (cnt == CW'(RST_HOLD - 1)) begin
            state       <= step_q ? STEP : RUN;
            idx         <= '0;
            core_reset  <= 1'b0;
            Instruction <= prog[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!at_last) begin
            idx         <= idx + 1'b1;
            Instruction <= prog[idx + 1'b1];
          end else if (loop_q) begin
            idx         <= '0;
            Instruction <= prog[0];
          end else begin
            state       <= DONE;
            Instruction <= NOP;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        STEP: begin
          if (step && !at_last) begin
            idx         <= idx + 1'b1;
            Instruction <= prog[idx + 1'b1];
          end else if (step) begin
            state       <= DONE;
            Instruction <= NOP;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tr_ent_t        tr_mem [TRACE_DEPTH];
  logic [TAW-1:0] wp;
  logic [TAW-1:0] rp;
  logic           push_req;
  logic           pop;
  logic           full;
  logic           do_push;
  logic           clear;

  assign push_req = MemWrite && ((state == RUN) || (state == STEP));
  assign pop      = tr.tr_valid && tr.tr_ready;
  assign full     = (tr_count == (TAW+1)'(TRACE_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push  = push_req && (!full || pop);
  assign clear    = start_ok && !abort;

  always_ff @(posedge clk) begin
    if (do_push)
      tr_mem[wp] <= '{pc: PC, addr: ALURes, data: WriteData};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      tr_count <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wp       <= '0;
      rp       <= '0;
      tr_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      if (do_push && !pop)
        tr_count <= tr_count + 1'b1;
      else if (pop && !do_push)
        tr_count <= tr_count - 1'b1;
      if (push_req && !do_push)
        overflow <= 1'b1;
    end
  end

  assign tr.tr_valid = (tr_count != '0);
  assign tr.tr_pc    = tr_mem[rp].pc;
  assign tr.tr_addr  = tr_mem[rp].addr;
  assign tr.tr_data  = tr_mem[rp].data;

endmodule

// File: tb/tb_core_stim_seq.sv
// Directed bench: expected instruction stream and trace entries are queued by the stimulus
// and popped by independent monitors; status outputs are checked inline.
module tb_core_stim_seq;
  localparam int XLEN = 32;
  localparam logic [31:0] INS_A = 32'h6AE0_13B7;
  localparam logic [31:0] INS_B = 32'hDEAD_B437;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0, step = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [31:0] prog_wdata = '0;
  logic [4:0]  prog_len = '0;
  logic        core_reset;
  logic [31:0] Instruction;
  logic [31:0] PC = '0, ALURes = '0, WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        busy, done, overflow;
  logic [3:0]  tr_count;

  core_stim_seq_if #(.XLEN(XLEN)) tr_if ();

  core_stim_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode), .step(step),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_len(prog_len),
    .core_reset(core_reset), .Instruction(Instruction), .PC(PC), .ALURes(ALURes),
    .WriteData(WriteData), .MemWrite(MemWrite), .tr(tr_if), .busy(busy), .done(done),
    .overflow(overflow), .tr_count(tr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } tr_t;

  int          checks = 0;
  int          errors = 0;
  bit          chk_instr = 1'b0;
  logic [31:0] exp_iq [$];
  tr_t         exp_tq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick(1);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode = m; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_tr(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
    tr_t e;
    e.pc = p; e.addr = a; e.data = d;
    exp_tq.push_back(e);
  endtask

  // Instruction monitor: one expected word per playback cycle.
  initial forever begin
    @(negedge clk); #1;
    if (chk_instr && reset && busy && !core_reset) begin
      if (exp_iq.size() == 0) begin
        checks++; errors++;
        $display("FAIL instr_unexpected: got 0x%08h, expected no playback", Instruction);
      end else begin
        chk("instr", Instruction, exp_iq.pop_front());
      end
    end
  end

  // Trace monitor: compare the head on every accepted pop.
  initial forever begin
    @(negedge clk); #1;
    if (reset && tr_if.tr_valid && tr_if.tr_ready) begin
      if (exp_tq.size() == 0) begin
        checks++; errors++;
        $display("FAIL tr_unexpected: got pc 0x%08h, expected empty", tr_if.tr_pc);
      end else begin
        tr_t e;
        e = exp_tq.pop_front();
        chk("tr_pc", tr_if.tr_pc, e.pc);
        chk("tr_addr", tr_if.tr_addr, e.addr);
        chk("tr_data", tr_if.tr_data, e.data);
      end
    end
  end

  initial begin
    tr_if.tr_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_instr", Instruction, NOP);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tr_count", tr_count, 0);
    chk("rst_tr_valid", tr_if.tr_valid, 0);
    chk("rst_overflow", overflow, 0);
    tick(1);
    reset = 1'b1;
    load(4'd0, INS_A);
    load(4'd1, INS_B);

    // Illegal lengths leave the sequencer idle.
    prog_len = 5'd0;
    pulse_start(2'b00);
    tick(1);
    chk("len0_core_reset", core_reset, 1);
    chk("len0_busy", busy, 0);
    prog_len = 5'd17;
    pulse_start(2'b00);
    tick(1);
    chk("len17_busy", busy, 0);
    prog_len = 5'd2;

    // Run-once.
    chk_instr = 1'b1;
    exp_iq.push_back(INS_A); exp_iq.push_back(INS_B);
    pulse_start(2'b00);
    chk("once_crst0_core_reset", core_reset, 1);
    chk("once_crst0_busy", busy, 1);
    tick(1);
    chk("once_crst1_core_reset", core_reset, 1);
    tick(1);
    chk("once_run_core_reset", core_reset, 0);
    tick(2);
    chk("once_done", done, 1);
    chk("once_done_busy", busy, 0);
    chk("once_done_instr", Instruction, NOP);
    chk("once_done_core_reset", core_reset, 0);
    chk("once_iq_drained", exp_iq.size(), 0);

    // Loop from DONE; mode change, program write and start during abort are all ignored.
    repeat (2) begin
      exp_iq.push_back(INS_A); exp_iq.push_back(INS_B);
    end
    exp_iq.push_back(INS_A);
    pulse_start(2'b01);
    mode = 2'b00;
    tick(3);
    chk("loop_core_reset", core_reset, 0);
    chk("loop_done", done, 0);
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 32'hFFFF_FFFF;
    tick(1);
    prog_we = 1'b0;
    tick(2);
    abort = 1'b1; start = 1'b1;
    tick(1);
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_core_reset", core_reset, 1);
    chk("abort_instr", Instruction, NOP);
    chk("loop_iq_drained", exp_iq.size(), 0);

    // Single-step: five held cycles, step to B, step to DONE.
    repeat (5) exp_iq.push_back(INS_A);
    repeat (2) exp_iq.push_back(INS_B);
    pulse_start(2'b10);
    tick(6);
    step = 1'b1; tick(1);
    step = 1'b0; tick(1);
    step = 1'b1; tick(1);
    step = 1'b0;
    chk("step_done", done, 1);
    chk("step_done_instr", Instruction, NOP);
    chk("step_iq_drained", exp_iq.size(), 0);

    // Trace FIFO fill, overflow, push+pop when full, drain.
    chk_instr = 1'b0;
    pulse_start(2'b01);
    tick(2);
    MemWrite = 1'b1; PC = 32'h10; ALURes = 32'h100; WriteData = 32'hCAFE;
    repeat (8) push_tr(32'h10, 32'h100, 32'hCAFE);
    tick(9);
    chk("fill_count", tr_count, 8);
    chk("fill_overflow", overflow, 1);
    chk("fill_valid", tr_if.tr_valid, 1);
    chk("head_pc", tr_if.tr_pc, 32'h10);
    chk("head_addr", tr_if.tr_addr, 32'h100);
    chk("head_data", tr_if.tr_data, 32'hCAFE);
    PC = 32'h20; ALURes = 32'h200; WriteData = 32'hBEEF;
    push_tr(32'h20, 32'h200, 32'hBEEF);
    tr_if.tr_ready = 1'b1;
    tick(1);
    MemWrite = 1'b0;
    chk("full_pushpop_count", tr_count, 8);
    chk("full_pushpop_overflow", overflow, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_keeps_fifo", tr_count, 7);
    chk("abort_idle_busy", busy, 0);
    tick(7);
    chk("drain_count", tr_count, 0);
    chk("drain_valid", tr_if.tr_valid, 0);
    chk("drain_tq_empty", exp_tq.size(), 0);
    tr_if.tr_ready = 1'b0;

    // Async reset mid-run, then replay with the program intact.
    pulse_start(2'b01);
    chk("start_clears_overflow", overflow, 0);
    tick(2);
    MemWrite = 1'b1;
    tick(2);
    MemWrite = 1'b0;
    chk("pre_reset_count", tr_count, 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_core_reset", core_reset, 1);
    chk("arst_instr", Instruction, NOP);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_tr_count", tr_count, 0);
    chk("arst_tr_valid", tr_if.tr_valid, 0);
    tick(1);
    reset = 1'b1;
    tick(2);
    chk("post_reset_idle_busy", busy, 0);
    chk("post_reset_core_reset", core_reset, 1);
    chk_instr = 1'b1;
    exp_iq.push_back(INS_A); exp_iq.push_back(INS_B);
    pulse_start(2'b00);
    tick(4);
    chk("replay_done", done, 1);
    chk("replay_iq_drained", exp_iq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_stim_seq.md
CORE_STIM_SEQ -- requirements
Module: core_stim_seq

Interface
REQ-001 Parameter XLEN, default 32, instruction/data width.
REQ-002 Parameter PROG_DEPTH, default 16, program buffer entries (power of 2, >=2).
REQ-003 Parameter TRACE_DEPTH, default 8, store-trace FIFO entries (power of 2, >=2).
REQ-004 Parameter RST_HOLD, default 2, cycles core_reset held asserted before playback (>=1).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low block reset.
REQ-007 start  in  1  playback request pulse; abort  in  1  synchronous return to IDLE.
REQ-008 mode  in  2  00 run-once, 01 loop, 10 single-step, 11 treated as 00.
REQ-009 step  in  1  advance one instruction in single-step mode.
REQ-010 prog_we  in  1, prog_addr  in  log2(PROG_DEPTH), prog_wdata  in  XLEN: program buffer write port.
REQ-011 prog_len  in  log2(PROG_DEPTH)+1  number of valid program words.
REQ-012 core_reset  out  1  active-high reset driven to the core.
REQ-013 Instruction  out  XLEN  instruction word presented to the core.
REQ-014 PC, ALURes, WriteData  in  XLEN; MemWrite  in  1: core outputs monitored.
REQ-015 tr_valid  out  1, tr_ready  in  1, tr_pc/tr_addr/tr_data  out  XLEN: store-trace FIFO read port.
REQ-016 busy  out  1, done  out  1, overflow  out  1  (sticky), tr_count  out  log2(TRACE_DEPTH)+1.

Function
REQ-017 FSM states SHALL be IDLE, CRST, RUN, STEP, DONE.
REQ-018 IDLE: core_reset=1, Instruction=NOP (0x00000013), busy=0, done=0.
REQ-019 prog_we SHALL write prog_wdata to prog_addr only in IDLE or DONE; ignored otherwise.
REQ-020 start in IDLE/DONE with prog_len!=0 -> CRST, clears overflow, empties trace FIFO; start with prog_len==0 or prog_len>PROG_DEPTH ignored.
REQ-021 CRST: core_reset=1, busy=1, for exactly RST_HOLD cycles, then RUN (modes 00/01) or STEP (mode 10) with idx=0.
REQ-022 RUN: core_reset=0, Instruction=prog[idx], idx increments by 1 per cycle.
REQ-023 RUN at idx==prog_len-1: mode 00 -> DONE next cycle; mode 01 -> idx wraps to 0, no core_reset pulse.
REQ-024 STEP: Instruction=prog[idx] held; step=1 advances idx; step at idx==prog_len-1 -> DONE.
REQ-025 mode SHALL be sampled on start only; changes during playback ignored.
REQ-026 DONE: Instruction=NOP, core_reset=0, done=1, busy=0; start re-enters CRST.
REQ-027 abort=1 in any state -> IDLE next cycle; abort beats start when simultaneous; trace FIFO contents preserved.
REQ-028 In RUN/STEP, MemWrite=1 at a rising edge SHALL push {PC, ALURes, WriteData} into the trace FIFO.
REQ-029 tr_valid = FIFO non-empty; pop on tr_valid && tr_ready; tr_* show head entry (first-word-fall-through).
REQ-030 Push when full and no pop: entry dropped, overflow set until next accepted start or reset.
REQ-031 Simultaneous push and pop when full: both accepted, tr_count unchanged, no overflow.
REQ-032 FIFO pointers SHALL wrap modulo TRACE_DEPTH; tr_count = occupied entries, 0..TRACE_DEPTH.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, core_reset=1, Instruction=NOP, idx=0, FIFO empty, tr_valid=0, overflow=0, busy=0, done=0, tr_count=0.
REQ-034 Program buffer contents SHALL NOT be cleared by reset; reset mid-playback aborts with no further trace pushes.
REQ-035 Release of reset SHALL take effect at the first rising edge after deassertion; FSM stays IDLE until start.

Verification
REQ-036 Load prog[0]=0x6AE013B7, prog[1]=0xDEADB437, len=2, mode 00, start -> core_reset 1 for 2 cycles, then Instruction 0x6AE013B7, 0xDEADB437, then NOP with done=1.
REQ-037 Same program, mode 01 -> sequence 0x6AE013B7, 0xDEADB437, 0x6AE013B7 repeating, core_reset stays 0, done=0 until abort -> IDLE.
REQ-038 Mode 10, len=2 -> Instruction held at 0x6AE013B7 for 5 cycles without step; one step -> 0xDEADB437; second step -> DONE.
REQ-039 Force MemWrite=1 with PC=0x10, ALURes=0x100, WriteData=0xCAFE for 9 cycles, tr_ready=0 -> tr_count=8, overflow=1, head = {0x10,0x100,0xCAFE}; then tr_ready=1 with push -> count stays 8.
REQ-040 Assert reset=0 mid-RUN between clock edges -> outputs reach reset values without a clock edge; after release, start replays from idx 0 with program intact.
REQ-041 start with prog_len=0 -> remains IDLE, core_reset=1, busy=0.
